// File: rtl/muldiv_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// muldiv_ctrl
//
// Sequencing controller for the calculator's shared multiply/divide datapath.
// It drives the control strobes of the multiplier/dividend shift register and
// runs either a 4x4 shift-add multiply or an 8/4 restoring divide. It reports
// busy/done back to the top-level calculator FSM.
//
// Optional feature macro: MULDIV_DIVZERO_EN
//   When defined, a divide whose divisor is zero is skipped. The controller
//   jumps from LOAD straight to DONE and raises err, which holds until the
//   next accepted start. When undefined, divisor_zero is ignored and err is
//   always 0.
//
// Ports:
//   clk, rst        - rising-edge clock, asynchronous active-high reset
//   start, op       - request an operation (op: 0 = multiply, 1 = divide),
//                     sampled only while idle
//   c               - multiplier LSB from the shift register
//   borrow          - ALU borrow for the current divide step
//   divisor_zero    - divisor operand is zero
//   ld_multiplier   - load multiplier into the shift register
//   ld_dividend     - load dividend into the shift register
//   ad              - add multiplicand into the upper product bits
//   su              - load subtraction result into the remainder bits
//   q_bit           - quotient bit shifted in with sh
//   sh              - right-shift the register
//   busy, done, err - status: in progress, one-cycle completion, div-by-zero
// ---------------------------------------------------------------------------
module muldiv_ctrl #(
    parameter int MUL_STEPS = 4,
    parameter int DIV_STEPS = 5,
    parameter int CNT_W     = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic op,
    input  logic c,
    input  logic borrow,
    input  logic divisor_zero,
    output logic ld_multiplier,
    output logic ld_dividend,
    output logic ad,
    output logic su,
    output logic q_bit,
    output logic sh,
    output logic busy,
    output logic done,
    output logic err
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        MUL_STEP,
        MUL_SH,
        DIV_STEP,
        DIV_SH,
        DONE
    } state_t;

    // The counter value seen during the final shift of each operation.
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_STEPS - 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_STEPS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             op_q, op_d;
    logic             q_bit_q, q_bit_d;

`ifdef MULDIV_DIVZERO_EN
    logic err_q, err_d;
`else
    logic unused_divisor_zero;
    assign unused_divisor_zero = divisor_zero;
`endif

    // State and datapath-side registers. Reset returns to IDLE with all
    // registered outputs cleared, so every strobe drops as soon as rst rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= 1'b0;
            q_bit_q <= 1'b0;
`ifdef MULDIV_DIVZERO_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            q_bit_q <= q_bit_d;
`ifdef MULDIV_DIVZERO_EN
            err_q   <= err_d;
`endif
        end
    end

    // Next-state and output decode. ad and su depend on c/borrow only in
    // their own step states. Every other strobe is a pure state decode.
    // The op used after IDLE is always the latched copy, so toggling the op
    // pin mid-operation has no effect.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        op_d          = op_q;
        q_bit_d       = q_bit_q;
`ifdef MULDIV_DIVZERO_EN
        err_d         = err_q;
`endif
        ld_multiplier = 1'b0;
        ld_dividend   = 1'b0;
        ad            = 1'b0;
        su            = 1'b0;
        q_bit         = 1'b0;
        sh            = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d    = op;
                    cnt_d   = '0;
`ifdef MULDIV_DIVZERO_EN
                    err_d   = 1'b0;
`endif
                    state_d = LOAD;
                end
            end

            LOAD: begin
                busy = 1'b1;
`ifdef MULDIV_DIVZERO_EN
                // A zero divisor skips the whole divide and never loads
                // the dividend.
                if (op_q && divisor_zero) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    ld_multiplier = ~op_q;
                    ld_dividend   = op_q;
                    state_d       = op_q ? DIV_STEP : MUL_STEP;
                end
`else
                ld_multiplier = ~op_q;
                ld_dividend   = op_q;
                state_d       = op_q ? DIV_STEP : MUL_STEP;
`endif
            end

            MUL_STEP: begin
                busy = 1'b1;
                // A set multiplier bit costs an extra add cycle before its
                // shift. A clear bit shifts right away.
                if (c) begin
                    ad      = 1'b1;
                    state_d = MUL_SH;
                end else begin
                    sh      = 1'b1;
                    cnt_d   = cnt_q + CNT_ONE;
                    state_d = (cnt_q == MUL_LAST) ? DONE : MUL_STEP;
                end
            end

            MUL_SH: begin
                busy    = 1'b1;
                sh      = 1'b1;
                cnt_d   = cnt_q + CNT_ONE;
                state_d = (cnt_q == MUL_LAST) ? DONE : MUL_STEP;
            end

            DIV_STEP: begin
                busy    = 1'b1;
                su      = ~borrow;
                q_bit_d = ~borrow;
                state_d = DIV_SH;
            end

            DIV_SH: begin
                busy    = 1'b1;
                sh      = 1'b1;
                q_bit   = q_bit_q;
                cnt_d   = cnt_q + CNT_ONE;
                state_d = (cnt_q == DIV_LAST) ? DONE : DIV_STEP;
            end

            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef MULDIV_DIVZERO_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_muldiv_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_muldiv_ctrl
//
// Directed scoreboard bench for muldiv_ctrl. Each operation pushes its
// hand-computed per-cycle output vectors into a queue. A monitor pops one
// vector on every falling edge while the queue holds entries.
// Vector layout: {ld_multiplier, ld_dividend, ad, su, sh, q_bit, busy, done, err}
// Masks passed to applyStimulus use bit k for cycle k, where edge 0 samples start.
// ---------------------------------------------------------------------------
module tb_muldiv_ctrl;

    logic clk = 1'b0;
    logic rst, start, op, c, borrow, divisor_zero;
    logic ld_multiplier, ld_dividend, ad, su, q_bit, sh, busy, done, err;

    int checkCount = 0;
    int errorCount = 0;

    logic [8:0] sbExp[$];
    string      sbName[$];
    int         sbCycle[$];

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    muldiv_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .op           (op),
        .c            (c),
        .borrow       (borrow),
        .divisor_zero (divisor_zero),
        .ld_multiplier(ld_multiplier),
        .ld_dividend  (ld_dividend),
        .ad           (ad),
        .su           (su),
        .q_bit        (q_bit),
        .sh           (sh),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    function automatic logic [8:0] actVec();
        return {ld_multiplier, ld_dividend, ad, su, sh, q_bit, busy, done, err};
    endfunction

    // Shared compare/report used by the monitor and the direct reset checks.
    task automatic checkOutput(input string name, input logic [8:0] act, input logic [8:0] exp);
        checkCount++;
        if (act !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got %b expected %b (ldm ldd ad su sh q busy done err)",
                     name, act, exp);
        end
    endtask

    // Monitor: consumes one expected vector per falling edge while entries remain.
    initial begin
        logic [8:0] expVec;
        string      nm;
        int         cy;
        forever begin
            @(negedge clk);
            if (sbExp.size() > 0) begin
                expVec = sbExp.pop_front();
                nm     = sbName.pop_front();
                cy     = sbCycle.pop_front();
                checkOutput($sformatf("%s_c%0d", nm, cy), actVec(), expVec);
            end
        end
    end

    // Issues one operation, queues its expected vectors for cycles 1..n and
    // drives c/borrow per cycle. With disturb set, start is re-pulsed and op
    // is inverted during cycles 2-4 to show both are ignored while busy.
    task automatic applyStimulus(
        input string name, input logic opIn, input logic dzIn,
        input logic [15:0] cM, input logic [15:0] bM, input int n,
        input logic [15:0] ldmM, input logic [15:0] lddM, input logic [15:0] adM,
        input logic [15:0] suM, input logic [15:0] shM, input logic [15:0] qbM,
        input logic [15:0] busyM, input logic [15:0] doneM, input logic [15:0] errM,
        input bit disturb);
        @(negedge clk);
        start        = 1'b1;
        op           = opIn;
        divisor_zero = dzIn;
        c            = 1'b0;
        borrow       = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 1; k <= n; k++) begin
            sbExp.push_back({ldmM[k], lddM[k], adM[k], suM[k], shM[k], qbM[k],
                             busyM[k], doneM[k], errM[k]});
            sbName.push_back(name);
            sbCycle.push_back(k);
        end
        for (int k = 1; k <= n; k++) begin
            c      = cM[k];
            borrow = bM[k];
            if (disturb && k >= 2 && k <= 4) begin
                start = 1'b1;
                op    = ~opIn;
            end else begin
                start = 1'b0;
                op    = opIn;
            end
            @(posedge clk);
            #1;
        end
        c            = 1'b0;
        borrow       = 1'b0;
        divisor_zero = 1'b0;
    endtask

    // Watchdog so a stuck run still ends with a report.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        op           = 1'b0;
        c            = 1'b0;
        borrow       = 1'b0;
        divisor_zero = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_init", actVec(), 9'b0);
        @(negedge clk);
        rst = 1'b0;

        // Mid-operation reset with start held high: outputs clear at once and no done appears.
        @(negedge clk);
        start = 1'b1;
        op    = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        c     = 1'b1;
        @(posedge clk); #1;
        c = 1'b1;
        @(posedge clk); #1;
        #1;
        rst   = 1'b1;
        start = 1'b1;
        #1;
        checkOutput("reset_async", actVec(), 9'b0);
        for (int k = 1; k <= 2; k++) begin
            sbExp.push_back(9'b0);
            sbName.push_back("reset_hold");
            sbCycle.push_back(k);
        end
        repeat (2) @(negedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        c     = 1'b0;

        // Multiply, multiplier 1011 (c = 1,1,0,1), with c noise outside the step cycles.
        applyStimulus("mul_1011", 1'b0, 1'b0, 16'h029E, 16'h0000, 10,
                      16'h0002, 16'h0000, 16'h0094, 16'h0000, 16'h0168, 16'h0000,
                      16'h03FE, 16'h0200, 16'h0000, 1'b0);

        // Multiply, multiplier 0, with borrow held high to show su never fires.
        applyStimulus("mul_0000", 1'b0, 1'b0, 16'h0000, 16'hFFFF, 7,
                      16'h0002, 16'h0000, 16'h0000, 16'h0000, 16'h003C, 16'h0000,
                      16'h007E, 16'h0040, 16'h0000, 1'b0);

        // Divide, borrow 1,0,1,1,0, with borrow noise in shift cycles and c held high.
        applyStimulus("div_10110", 1'b1, 1'b0, 16'hFFFF, 16'h016C, 13,
                      16'h0000, 16'h0002, 16'h0000, 16'h0410, 16'h0AA8, 16'h0820,
                      16'h1FFE, 16'h1000, 16'h0000, 1'b0);

        // Same operations with start re-pulsed and op inverted while busy.
        applyStimulus("mul_disturb", 1'b0, 1'b0, 16'h029E, 16'h0000, 10,
                      16'h0002, 16'h0000, 16'h0094, 16'h0000, 16'h0168, 16'h0000,
                      16'h03FE, 16'h0200, 16'h0000, 1'b1);
        applyStimulus("div_disturb", 1'b1, 1'b0, 16'hFFFF, 16'h016C, 13,
                      16'h0000, 16'h0002, 16'h0000, 16'h0410, 16'h0AA8, 16'h0820,
                      16'h1FFE, 16'h1000, 16'h0000, 1'b1);

        // Divide by zero.
`ifdef MULDIV_DIVZERO_EN
        applyStimulus("div_zero", 1'b1, 1'b1, 16'h0000, 16'h016C, 4,
                      16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                      16'h0006, 16'h0004, 16'h001C, 1'b0);
`else
        applyStimulus("div_zero", 1'b1, 1'b1, 16'h0000, 16'h016C, 13,
                      16'h0000, 16'h0002, 16'h0000, 16'h0410, 16'h0AA8, 16'h0820,
                      16'h1FFE, 16'h1000, 16'h0000, 1'b0);
`endif

        // A following normal divide must clear err from its first cycle on.
        applyStimulus("div_after_zero", 1'b1, 1'b0, 16'h0000, 16'h016C, 13,
                      16'h0000, 16'h0002, 16'h0000, 16'h0410, 16'h0AA8, 16'h0820,
                      16'h1FFE, 16'h1000, 16'h0000, 1'b0);

        for (int i = 0; i < 50 && sbExp.size() > 0; i++) @(posedge clk);
        checkCount++;
        if (sbExp.size() != 0) begin
            errorCount++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", sbExp.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
